// File: rtl/mem_arbiter_rr_if.sv
// Bundle of per-CPU cache request/response lanes and the shared RAM port.
// The arbiter connects through the master view; the environment uses the slave view.
interface mem_arbiter_rr_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*WORD_W-1:0] iaddr;
    logic [CPUS*WORD_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS*WORD_W-1:0] dload;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic                   ramREN;
    logic                   ramWEN;
    logic [CPUS-1:0]        rerr;

    modport master (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, rerr
    );

    modport slave (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, rerr
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one RAM port among CPUS I/D cache pairs.
// IDLE picks a winner, XFER drives the RAM from the registered grant until completion.
module mem_arbiter_rr #(
    parameter int CPUS      = 2,
    parameter int WORD_W    = 32,
    parameter int ERR_RETRY = 1
) (
    input  logic               CLK,
    input  logic               nRST,
    mem_arbiter_rr_if.master   bus
);
    localparam int                CPU_W    = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [CPU_W:0]    CPUS_L   = (CPU_W+1)'(CPUS);
    localparam logic [CPU_W-1:0]  CPU_LAST = CPU_W'(CPUS - 1);
    localparam logic [1:0]        RAM_ACCESS = 2'd2;
    localparam logic [1:0]        RAM_ERROR  = 2'd3;

    typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;
    typedef enum logic [1:0] {SRC_DRD = 2'd0, SRC_DWR = 2'd1, SRC_IRD = 2'd2} src_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CPU_W-1:0]  rr_r;
    logic [CPU_W-1:0]  rr_nxt_s;
    logic [CPU_W-1:0]  gnt_cpu_r;
    src_t              gnt_src_r;

    logic [WORD_W-1:0] iaddr_s  [CPUS];
    logic [WORD_W-1:0] daddr_s  [CPUS];
    logic [WORD_W-1:0] dstore_s [CPUS];
    logic [CPUS-1:0]   has_req_s;

    logic              win_found_s;
    logic [CPU_W-1:0]  win_cpu_s;
    src_t              win_src_s;
    logic [CPU_W:0]    cand_s;

    logic              req_live_s;
    logic              done_s;
    logic              ram_ren_s;
    logic              ram_wen_s;
    logic [WORD_W-1:0] ramaddr_s;
    logic [WORD_W-1:0] ramstore_s;
    logic [CPUS-1:0]   iwait_s;
    logic [CPUS-1:0]   dwait_s;
    logic [CPUS-1:0]   rerr_s;

    for (genvar k = 0; k < CPUS; k++) begin : g_slice
        assign iaddr_s[k]  = bus.iaddr[k*WORD_W +: WORD_W];
        assign daddr_s[k]  = bus.daddr[k*WORD_W +: WORD_W];
        assign dstore_s[k] = bus.dstore[k*WORD_W +: WORD_W];
        assign bus.iload[k*WORD_W +: WORD_W] = bus.ramload;
        assign bus.dload[k*WORD_W +: WORD_W] = bus.ramload;
    end

    assign has_req_s = bus.dREN | bus.dWEN | bus.iREN;

    // Round-robin winner search from rr, then intra-CPU source priority.
    always_comb begin
        win_found_s = 1'b0;
        win_cpu_s   = '0;
        win_src_s   = SRC_IRD;
        cand_s      = '0;
        for (int i = 0; i < CPUS; i++) begin
            cand_s = {1'b0, rr_r} + (CPU_W+1)'(i);
            if (cand_s >= CPUS_L) begin
                cand_s = cand_s - CPUS_L;
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && has_req_s[cand_s[CPU_W-1:0]]) begin
                win_found_s = 1'b1;
                win_cpu_s   = cand_s[CPU_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
        if (bus.dREN[win_cpu_s]) begin
            win_src_s = SRC_DRD;
        end else if (bus.dWEN[win_cpu_s]) begin
            win_src_s = SRC_DWR;
        end else begin
            win_src_s = SRC_IRD;
        end
    end

    // Whether the granted request is still asserted, and whether this cycle completes it.
    always_comb begin
        case (gnt_src_r)
            SRC_DRD: req_live_s = bus.dREN[gnt_cpu_r];
            SRC_DWR: req_live_s = bus.dWEN[gnt_cpu_r];
            SRC_IRD: req_live_s = bus.iREN[gnt_cpu_r];
            default: req_live_s = 1'b0;
        endcase
        done_s = (bus.ramstate == RAM_ACCESS) ||
                 ((bus.ramstate == RAM_ERROR) && (ERR_RETRY == 0));
    end

    // Next state and RAM/wait outputs; a low nRST forces the idle output values immediately.
    always_comb begin
        state_nxt_s = state_r;
        rr_nxt_s    = rr_r;
        ram_ren_s   = 1'b0;
        ram_wen_s   = 1'b0;
        ramaddr_s   = '0;
        ramstore_s  = '0;
        iwait_s     = '1;
        dwait_s     = '1;
        rerr_s      = '0;
        if (nRST) begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        state_nxt_s = ST_XFER;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_XFER: begin
                    ramaddr_s  = (gnt_src_r == SRC_IRD) ? iaddr_s[gnt_cpu_r] : daddr_s[gnt_cpu_r];
                    ramstore_s = (gnt_src_r == SRC_DWR) ? dstore_s[gnt_cpu_r] : '0;
                    if (!req_live_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        ram_ren_s = (gnt_src_r != SRC_DWR);
                        ram_wen_s = (gnt_src_r == SRC_DWR);
                        if (done_s) begin
                            if (gnt_src_r == SRC_IRD) begin
                                iwait_s[gnt_cpu_r] = 1'b0;
                            end else begin
                                dwait_s[gnt_cpu_r] = 1'b0;
                            end
                            rerr_s[gnt_cpu_r] = (bus.ramstate == RAM_ERROR);
                            state_nxt_s = ST_IDLE;
                            rr_nxt_s    = (gnt_cpu_r == CPU_LAST) ? '0 : gnt_cpu_r + CPU_W'(1);
                        end else begin
                            state_nxt_s = ST_XFER;
                        end
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // State, round-robin pointer and grant registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r   <= ST_IDLE;
            rr_r      <= '0;
            gnt_cpu_r <= '0;
            gnt_src_r <= SRC_DRD;
        end else begin
            state_r <= state_nxt_s;
            rr_r    <= rr_nxt_s;
            if ((state_r == ST_IDLE) && win_found_s) begin
                gnt_cpu_r <= win_cpu_s;
                gnt_src_r <= win_src_s;
            end
        end
    end

    assign bus.ramREN   = ram_ren_s;
    assign bus.ramWEN   = ram_wen_s;
    assign bus.ramaddr  = ramaddr_s;
    assign bus.ramstore = ramstore_s;
    assign bus.iwait    = iwait_s;
    assign bus.dwait    = dwait_s;
    assign bus.rerr     = rerr_s;
endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter CPUS, default 2: number of cache pairs (one I-cache and one D-cache each) sharing one RAM port; legal range 1..8.
REQ-002 SHALL have parameter WORD_W, default 32: width of addresses and data words.
REQ-003 SHALL have parameter ERR_RETRY, default 1: 1 = retry on ramstate ERROR; 0 = complete with error.
REQ-004 SHALL have port CLK, in, 1: the block's single clock; all state changes on its rising edge.
REQ-005 SHALL have port nRST, in, 1: reset, synchronous and active-low, sampled on the rising edge of CLK.
REQ-006 SHALL have ports iREN / dREN / dWEN, in, CPUS each: per-CPU instruction read, data read and data write requests.
REQ-007 SHALL have ports iaddr / daddr / dstore, in, CPUS*WORD_W each: per-CPU instruction address, data address and write data; CPU k occupies bits [k*WORD_W +: WORD_W].
REQ-008 SHALL have ports iwait / dwait, out, CPUS each: per-CPU stall; low for exactly the cycle the request completes.
REQ-009 SHALL have ports iload / dload, out, CPUS*WORD_W each: ramload broadcast to every CPU slice.
REQ-010 SHALL have port ramload, in, WORD_W: RAM read data.
REQ-011 SHALL have port ramstate, in, 2: RAM status; FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-012 SHALL have ports ramaddr / ramstore, out, WORD_W each: RAM address and RAM write data.
REQ-013 SHALL have ports ramREN / ramWEN, out, 1 each: RAM read enable and RAM write enable.
REQ-014 SHALL have port rerr, out, CPUS: one-cycle pulse flagging an errored completion for the CPU that owns it.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and XFER.
REQ-016 Source selection in IDLE SHALL work as follows:
- each CPU presents at most one source per cycle;
- priority within a CPU is dREN > dWEN > iREN;
- across CPUs, priority is round-robin starting at pointer rr.
REQ-017 In IDLE with any request pending, the next edge SHALL register the winning CPU index and source type and move the FSM to XFER.
REQ-018 In IDLE, ramREN and ramWEN SHALL be 0, ramaddr and ramstore SHALL be 0, and all wait bits SHALL be 1.
REQ-019 In XFER, the RAM outputs SHALL be driven combinationally from the registered grant:
- ramaddr = the granted daddr or iaddr slice;
- ramstore = the granted dstore slice when the source is a write, else 0;
- exactly one of ramREN / ramWEN = 1.
REQ-020 In XFER with ramstate == ACCESS, the granted wait bit SHALL be 0 in that same cycle; at the next edge the FSM SHALL return to IDLE and rr SHALL become (granted CPU + 1) mod CPUS.
REQ-021 In XFER with ramstate FREE or BUSY, the FSM SHALL hold and all wait bits SHALL stay 1.
REQ-022 In XFER with ramstate == ERROR:
- ERR_RETRY=1: hold, re-issuing the same access;
- ERR_RETRY=0: treat as completion, drive the granted wait bit to 0 and rerr[k] to 1 for one cycle, return to IDLE, advance rr.
REQ-023 If the granted request bit drops during XFER, that cycle SHALL deassert ramREN/ramWEN, keep all waits at 1, and return the FSM to IDLE at the next edge without advancing rr.
REQ-024 At most one wait bit SHALL be 0 in any cycle, and ramREN & ramWEN SHALL never both be 1.
REQ-025 Minimum latency from request to wait low SHALL be 2 cycles: one arbitration edge plus ACCESS in the first XFER cycle.
REQ-026 An unchanged request that is still asserted after completion SHALL be treated as a new request and re-arbitrated.
REQ-027 With CPUS=1, the block SHALL behave as a fixed-priority dREN > dWEN > iREN arbiter with the same timing.

Reset
REQ-028 When nRST=0 at an edge, the FSM SHALL go to IDLE, rr to 0 and the grant registers to 0, aborting any XFER in progress with no completion signalled.
REQ-029 During reset and in the first cycle after it, ramREN = ramWEN = 0, ramaddr = ramstore = 0, all iwait/dwait = 1 and rerr = 0.

Verification
REQ-030 Single read, CPUS=2: CPU0 dREN, daddr=0x100; ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 from cycle 1; dwait[0]=0 in cycle 3 only; dload slice 0 = 0xDEADBEEF.
REQ-031 Round-robin: CPU0 and CPU1 both assert iREN continuously with ACCESS immediate -> grants alternate 0,1,0,1, each completion separated by one IDLE cycle.
REQ-032 Intra-CPU priority: CPU1 dWEN=1 and iREN=1 together, daddr=0x40, dstore=0x5 -> write issued first (ramWEN=1, ramstore=0x5); iREN is served only after dwait[1] pulses low.
REQ-033 Abort and reset: CPU0 drops dREN mid-XFER -> FSM returns to IDLE with rr unchanged; separately, nRST=0 mid-XFER -> all outputs reach their reset values at the next edge.
REQ-034 Error: ERR_RETRY=0 with ramstate=ERROR -> dwait[k]=0 and rerr[k]=1 for one cycle; ERR_RETRY=1 -> access held until ACCESS, rerr stays 0.
